// File: rtl/wb_sram_bridge_pkg.sv
// -----------------------------------------------------------------------------
// rvj1_mem_pkg
// Shared definitions for the SRAM-side memory subsystem: bridge FSM state
// codes, macro data/mask widths, the IRAM/DRAM window map used by the SoC top,
// and the address-window compare reused by the SoC address decoder.
// -----------------------------------------------------------------------------
package rvj1_mem_pkg;

  localparam int SRAM_DATA_WIDTH = 32;
  localparam int SRAM_MASK_WIDTH = 4;

  // Memory map shared with the SoC top.
  localparam logic [31:0] IRAM_BASE_ADDR        = 32'h3000_0000;
  localparam int          IRAM_ADDR_WIDTH_WORDS = 9;
  localparam logic [31:0] DRAM_BASE_ADDR        = 32'h3000_1000;
  localparam int          DRAM_ADDR_WIDTH_WORDS = 9;

  // Bridge FSM encoding, kept as plain constants for legacy tool flows.
  typedef logic [1:0] bridge_state_t;
  localparam bridge_state_t ST_IDLE    = 2'd0;
  localparam bridge_state_t ST_RD_WAIT = 2'd1;
  localparam bridge_state_t ST_ACK     = 2'd2;

  // True when a byte address lies inside [base, base + 4*2^aw_words).
  // The subtraction is 32-bit unsigned, so addresses below the base wrap to
  // large offsets and fall outside the window. The span is held in 33 bits
  // so a window covering the full 4 GiB would not overflow.
  function automatic logic addr_in_window(input logic [31:0] adr,
                                          input logic [31:0] base,
                                          input int unsigned aw_words);
    logic [31:0] offset;
    logic [32:0] span;
    offset = adr - base;
    span   = 33'd4 << aw_words;
    return ({1'b0, offset} < span);
  endfunction

endpackage

// File: rtl/wb_sram_bridge_if.sv
// -----------------------------------------------------------------------------
// wb_sram_bridge_if
// Wishbone B4 classic bus bundle between the SoC memory-side master and the
// SRAM bridge slave.
//   master modport : drives cyc/stb/we/sel/adr/dat_i, receives ack/dat_o
//   slave  modport : receives cyc/stb/we/sel/adr/dat_i, drives ack/dat_o
// -----------------------------------------------------------------------------
interface wb_sram_bridge_if;
  import rvj1_mem_pkg::*;

  logic                       wbs_cyc_i;
  logic                       wbs_stb_i;
  logic                       wbs_we_i;
  logic [SRAM_MASK_WIDTH-1:0] wbs_sel_i;
  logic [31:0]                wbs_adr_i;
  logic [SRAM_DATA_WIDTH-1:0] wbs_dat_i;
  logic                       wbs_ack_o;
  logic [SRAM_DATA_WIDTH-1:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/wb_sram_bridge.sv
// -----------------------------------------------------------------------------
// wb_sram_bridge
// Wishbone B4 classic slave in front of one single-port (1rw) OpenRAM macro.
// Writes ack one cycle after acceptance, reads two cycles after acceptance
// (macro output is registered into wbs_dat_o). Addresses outside the window
// are acked with zero data without touching the macro and set a sticky flag.
//
// Ports:
//   wb_clk_i     in   system clock, forwarded to the macro as sram_clk0
//   wb_rst_i     in   asynchronous active-high reset
//   wb           slv  Wishbone bus (cyc/stb/we/sel/adr/dat_i, ack/dat_o)
//   sram_clk0    out  macro clock (= wb_clk_i)
//   sram_csb0    out  macro chip select, active-low
//   sram_web0    out  macro write enable, active-low
//   sram_wmask0  out  macro byte write mask
//   sram_addr0   out  macro word address (wbs_adr_i[ADDR_WIDTH_WORDS+1:2])
//   sram_din0    out  macro write data
//   sram_dout0   in   macro read data, valid the cycle after a read sample
//   oor_o        out  sticky out-of-range access flag
// -----------------------------------------------------------------------------
module wb_sram_bridge
  import rvj1_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR        = 32'h3000_0000,
  parameter int          ADDR_WIDTH_WORDS = 9,
  parameter int          DATA_WIDTH       = 32
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  wb_sram_bridge_if.slave             wb,
  output logic                        sram_clk0,
  output logic                        sram_csb0,
  output logic                        sram_web0,
  output logic [SRAM_MASK_WIDTH-1:0]  sram_wmask0,
  output logic [ADDR_WIDTH_WORDS-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0]       sram_din0,
  input  logic [DATA_WIDTH-1:0]       sram_dout0,
  output logic                        oor_o
);

  bridge_state_t         state_q, state_d;
  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  oor_q, oor_d;

  logic req;
  logic in_range;
  logic macro_sel;

  assign req       = wb.wbs_cyc_i & wb.wbs_stb_i;
  assign in_range  = addr_in_window(wb.wbs_adr_i, BASE_ADDR, ADDR_WIDTH_WORDS);
  // Reset gates the select so a master still holding stb during reset cannot
  // reach the macro.
  assign macro_sel = ~wb_rst_i & (state_q == ST_IDLE) & req & in_range;

  assign sram_clk0  = wb_clk_i;
  assign sram_addr0 = wb.wbs_adr_i[ADDR_WIDTH_WORDS+1:2];
  assign sram_din0  = wb.wbs_dat_i;

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign oor_o        = oor_q;

  // Macro control: active only for an in-range request seen in IDLE.
  always_comb begin
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = 4'h0;
    if (macro_sel) begin
      sram_csb0   = 1'b0;
      sram_web0   = ~wb.wbs_we_i;
      sram_wmask0 = wb.wbs_we_i ? wb.wbs_sel_i : 4'h0;
    end else begin
      sram_csb0   = 1'b1;
      sram_web0   = 1'b1;
      sram_wmask0 = 4'h0;
    end
  end

  // Next-state, ack, read-data and sticky out-of-range logic.
  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    oor_d   = oor_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (in_range && !wb.wbs_we_i) begin
            state_d = ST_RD_WAIT;
          end else begin
            // Writes and out-of-range requests ack next cycle with zero data.
            state_d = ST_ACK;
            dat_d   = {DATA_WIDTH{1'b0}};
            if (!in_range) begin
              oor_d = 1'b1;
            end else begin
              oor_d = oor_q;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        // Dropping cyc abandons the read; last data is preserved.
        if (wb.wbs_cyc_i) begin
          dat_d   = sram_dout0;
          state_d = ST_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        // Requests are ignored here so a held stb is not accepted twice.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ack_d = (state_d == ST_ACK);
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= {DATA_WIDTH{1'b0}};
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      oor_q   <= oor_d;
    end
  end

endmodule

// File: tb/tb_wb_sram_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb_sram_bridge
// Scoreboard bench for wb_sram_bridge. A driver issues Wishbone cycles and
// pushes the expected response (data + ack cycle) computed from a word-array
// reference model; a monitor pops and compares on every ack. A behavioural
// 1rw macro model answers the bridge's SRAM port.
// -----------------------------------------------------------------------------
module tb_wb_sram_bridge;
  import rvj1_mem_pkg::*;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          AW    = 9;
  localparam logic [31:0] SPAN  = 32'd2048;

  typedef struct {
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        sram_clk0, sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [31:0] sram_din0, sram_dout0;
  logic        oor_o;

  wb_sram_bridge_if wb ();

  wb_sram_bridge #(
    .BASE_ADDR       (BASE),
    .ADDR_WIDTH_WORDS(AW),
    .DATA_WIDTH      (32)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb         (wb),
    .sram_clk0  (sram_clk0),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_wmask0(sram_wmask0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0),
    .oor_o      (oor_o)
  );

  int          vectors = 0;
  int          fails   = 0;
  int          cyc_n   = 0;
  int          ack_cnt = 0;
  exp_t        sb[$];
  logic [31:0] ref_mem [512];
  logic [31:0] sram_mem[512];
  logic        exp_oor = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Behavioural 1rw macro: sample on rising edge, registered read data.
  always @(posedge sram_clk0) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b]) sram_mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
      end else begin
        sram_dout0 <= sram_mem[sram_addr0];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && wb.wbs_ack_o) begin
      ack_cnt++;
      chk("ack_cycle_csb0_idle", {31'd0, sram_csb0}, 32'd1);
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_data", wb.wbs_dat_o, e.dat);
        chk("ack_cycle", cyc_n, e.cyc);
      end
    end
  end

  // Drive one request (called just after a falling edge), check macro port
  // drive in the acceptance cycle, update reference and scoreboard.
  task automatic start(input logic we, input logic [31:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat);
    logic [31:0] off;
    logic        inr;
    logic [8:0]  idx;
    exp_t        e;
    off = adr - BASE;
    inr = (off < SPAN);
    idx = off[10:2];
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_adr_i = adr;
    wb.wbs_sel_i = sel;
    wb.wbs_dat_i = dat;
    #1;
    if (inr) begin
      chk("csb0", {31'd0, sram_csb0}, 32'd0);
      chk("web0", {31'd0, sram_web0}, {31'd0, ~we});
      chk("wmask0", {28'd0, sram_wmask0}, we ? {28'd0, sel} : 32'd0);
      chk("addr0", {23'd0, sram_addr0}, {23'd0, idx});
    end else begin
      chk("oor_csb0", {31'd0, sram_csb0}, 32'd1);
    end
    e.cyc = cyc_n + ((inr && !we) ? 2 : 1);
    if (!inr) begin
      e.dat   = 32'd0;
      exp_oor = 1'b1;
    end else if (we) begin
      e.dat = 32'd0;
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
    end else begin
      e.dat = ref_mem[idx];
    end
    sb.push_back(e);
  endtask

  task automatic wait_ack();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (wb.wbs_ack_o) got = 1'b1;
    end
    if (!got) begin
      chk("ack_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic idle_bus();
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr,
                      input logic [3:0] sel, input logic [31:0] dat);
    start(we, adr, sel, dat);
    wait_ack();
    idle_bus();
    chk("oor_o", {31'd0, oor_o}, {31'd0, exp_oor});
    @(negedge clk);
  endtask

  initial begin
    int          acks0;
    logic [31:0] adr, hold;
    for (int i = 0; i < 512; i++) begin
      ref_mem[i]  = 32'd0;
      sram_mem[i] = 32'd0;
    end
    sram_dout0 = 32'd0;
    idle_bus();
    wb.wbs_sel_i = 4'h0;
    wb.wbs_adr_i = 32'd0;
    wb.wbs_dat_i = 32'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
    chk("rst_dat", wb.wbs_dat_o, 32'd0);
    chk("rst_oor", {31'd0, oor_o}, 32'd0);
    chk("rst_csb0", {31'd0, sram_csb0}, 32'd1);
    chk("rst_web0", {31'd0, sram_web0}, 32'd1);
    chk("rst_wmask0", {28'd0, sram_wmask0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full-word write then read back.
    xfer(1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF);
    xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0);

    // Byte-lane write merge.
    xfer(1'b1, 32'h3000_0020, 4'hF, 32'h1122_3344);
    xfer(1'b1, 32'h3000_0020, 4'b0010, 32'h0000_5A00);
    xfer(1'b0, 32'h3000_0020, 4'hF, 32'h0);
    // sel=0 write changes nothing.
    xfer(1'b1, 32'h3000_0020, 4'h0, 32'hFFFF_FFFF);
    xfer(1'b0, 32'h3000_0020, 4'hF, 32'h0);

    // Held stb across two reads: acks at T+2 and T+5.
    xfer(1'b1, 32'h3000_0004, 4'hF, 32'hCAFE_0004);
    acks0 = ack_cnt;
    start(1'b0, 32'h3000_0000, 4'hF, 32'h0);
    wait_ack();
    wb.wbs_adr_i = 32'h3000_0004;
    @(negedge clk);
    start(1'b0, 32'h3000_0004, 4'hF, 32'h0);
    wait_ack();
    idle_bus();
    repeat (3) @(negedge clk);
    chk("held_stb_ack_count", ack_cnt - acks0, 32'd2);

    // Abort: cyc dropped in RD_WAIT, no ack, data kept, next request normal.
    acks0 = ack_cnt;
    hold  = wb.wbs_dat_o;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_adr_i = 32'h3000_0010;
    @(negedge clk);
    idle_bus();
    @(negedge clk);
    xfer(1'b1, 32'h3000_0030, 4'hF, 32'h0BAD_F00D);
    chk("abort_ack_count", ack_cnt - acks0, 32'd1);
    chk("abort_dat_kept_before_write", hold, 32'hCAFE_0004);

    // Randomized traffic including occasional out-of-window addresses.
    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      adr = BASE + SPAN + 32'($urandom_range(0, 1000)) * 32'd4;
      else if (r == 1) adr = BASE - 32'($urandom_range(1, 100)) * 32'd4;
      else             adr = BASE + 32'($urandom_range(0, 511)) * 32'd4 + 32'($urandom_range(0, 3));
      xfer(1'($urandom_range(0, 1)), adr, 4'($urandom_range(0, 15)), $urandom);
    end

    // Reset between random and directed out-of-range checks clears oor.
    rst = 1'b1;
    exp_oor = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("oor_cleared", {31'd0, oor_o}, 32'd0);
    xfer(1'b0, 32'h3000_0800, 4'hF, 32'h0);
    xfer(1'b1, 32'h2FFF_FFFC, 4'hF, 32'h1234_5678);
    xfer(1'b1, 32'h3000_0040, 4'hF, 32'h5555_AAAA);
    xfer(1'b0, 32'h3000_0040, 4'hF, 32'h0);
    chk("oor_sticky", {31'd0, oor_o}, 32'd1);

    // Asynchronous reset in RD_WAIT.
    start(1'b0, 32'h3000_0040, 4'hF, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    exp_oor = 1'b0;
    chk("arst_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
    chk("arst_csb0", {31'd0, sram_csb0}, 32'd1);
    chk("arst_dat", wb.wbs_dat_o, 32'd0);
    chk("arst_oor", {31'd0, oor_o}, 32'd0);
    @(negedge clk);
    idle_bus();
    rst = 1'b0;
    @(negedge clk);
    xfer(1'b1, 32'h3000_0044, 4'hF, 32'h7777_8888);
    xfer(1'b0, 32'h3000_0044, 4'hF, 32'h0);
    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_sram_bridge.md
Name: wb_sram_bridge

Overview:
- Wishbone B4 classic slave that turns bus cycles into single-port accesses on a sky130 OpenRAM macro (1rw port: clk0/csb0/web0/wmask0/addr0/din0/dout0).
- Sits directly upstream of the instruction and data SRAM macros, between the SoC's memory-side Wishbone and the macro port.
- Generates acks, registers read data, and answers out-of-window addresses without touching the macro.
- One instance per macro (IRAM, DRAM).

Parameters:
- BASE_ADDR, 32'h3000_0000, byte base address of the SRAM window.
- ADDR_WIDTH_WORDS, 9, macro word-address width; window is 4*2^ADDR_WIDTH_WORDS bytes.
- DATA_WIDTH, 32, data width; fixed at 32, with one wmask bit per byte.

Ports:
- wb_clk_i  in  1  system clock; also forwarded to the macro.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge, one-cycle pulse.
- wbs_dat_o  out  32  read data, valid only while ack is high.
- sram_clk0  out  1  equals wb_clk_i.
- sram_csb0  out  1  chip select, active-low.
- sram_web0  out  1  write enable, active-low.
- sram_wmask0  out  4  byte write mask.
- sram_addr0  out  ADDR_WIDTH_WORDS  word address, taken from wbs_adr_i[ADDR_WIDTH_WORDS+1:2].
- sram_din0  out  32  write data.
- sram_dout0  in  32  read data; valid in the cycle after a read is sampled.
- oor_o  out  1  sticky flag: an out-of-range access has occurred.

Behaviour:
- Reset (asynchronous, wb_rst_i=1): state=IDLE, wbs_ack_o=0, wbs_dat_o=0, oor_o=0, sram_csb0=1, sram_web0=1, sram_wmask0=0. Reset mid-transaction abandons it: no ack, no macro access after reset asserts.
- States: IDLE, RD_WAIT, ACK.
- Request = wbs_cyc_i & wbs_stb_i, considered in IDLE only.
- In-range test: (wbs_adr_i - BASE_ADDR) < 4*2^ADDR_WIDTH_WORDS, computed as 32-bit unsigned. Addresses below BASE_ADDR wrap to large values and are therefore out of range. wbs_adr_i[1:0] is ignored.
- Macro port drive: combinational from bus inputs, only in IDLE with an in-range request.
  - sram_csb0=0; sram_web0=~wbs_we_i.
  - sram_wmask0 = wbs_we_i ? wbs_sel_i : 4'h0.
  - Otherwise sram_csb0=1, sram_web0=1, sram_wmask0=0.
  - sram_addr0 and sram_din0 pass through at all times.
- In-range write, accepted in cycle T: the macro samples at the end of T. IDLE->ACK; wbs_ack_o=1 in T+1.
  - Write with wbs_sel_i=0 still selects the macro with wmask=0, so no byte changes, and acks in T+1.
- In-range read, accepted in T: IDLE->RD_WAIT. In T+1, sram_dout0 is captured into the wbs_dat_o register; RD_WAIT->ACK. wbs_ack_o=1 in T+2 with that data.
- Out-of-range request in T: no macro access; oor_o set to 1 (sticky until reset); IDLE->ACK; ack in T+1 with wbs_dat_o=0.
- ACK: wbs_ack_o=1 for exactly one cycle, then ->IDLE. No request is accepted in the ACK cycle, so a held stb is not double-accepted. The earliest back-to-back acceptance is the cycle after the ack.
- Abort: wbs_cyc_i=0 while in RD_WAIT -> IDLE next cycle, no ack, wbs_dat_o unchanged.
- wbs_dat_o holds its last value outside ack. It is 0 after any write or out-of-range ack.
- Throughput: at most one transaction per 2 cycles (write) or 3 cycles (read).

Decomposition:
- Package rvj1_mem_pkg holds:
  - the state enum (IDLE, RD_WAIT, ACK);
  - SRAM_DATA_WIDTH=32 and SRAM_MASK_WIDTH=4;
  - the IRAM/DRAM base addresses and word widths, shared with the SoC top.
- No sub-module is needed. The address-window compare is a local function in the package so the SoC decoder reuses it.

Test Plan:
- Write 32'hDEAD_BEEF to 32'h3000_0010, sel=4'hF: csb0=0, web0=0, wmask0=4'hF, addr0=4 in T; ack in T+1. Read of the same address acks in T+2 with 32'hDEAD_BEEF.
- Byte write sel=4'b0010, data 32'h0000_5A00, to a word holding 32'h1122_3344: wmask0=4'b0010; a later read returns 32'h1122_5A44.
- Access 32'h3000_0800 (one past the top for AW=9) and 32'h2FFF_FFFC: csb0 stays 1, ack in T+1 with data 0, oor_o=1 and stays 1 until reset.
- Master holds stb high across two reads (0x0 then 0x4, address changed after ack): exactly two acks, in T+2 and T+5, with no duplicate access during the ack cycles.
- Read accepted, then cyc dropped in T+1: no ack, FSM back in IDLE at T+2, next request accepted normally.
- wb_rst_i asserted asynchronously mid-read (between clock edges, in RD_WAIT): ack=0, csb0=1, dat_o=0, oor_o=0 immediately; after release, a fresh write acks in T+1.
